snn_layer_controller: RTL

SNN_LAYER_CONTROLLER -- requirements
Module: snn_layer_controller

---
 rtl/snn_pkg.sv | 26 ++
 rtl/snn_idx_counter.sv | 33 +++
 rtl/snn_layer_controller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared types and default constants for the SNN layer controller.
package snn_pkg;

    // Controller phases; encoding 3'd7 is unused and recovers to IDLE.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ACCUM   = 3'd2,
        SPIKE   = 3'd3,
        CLEANUP = 3'd4,
        LEAK    = 3'd5,
        STORE   = 3'd6
    } state_t;

    localparam int DEF_NUM_NEURONS = 16;
    localparam int DEF_NUM_INPUTS  = 16;
    localparam int DEF_PERIOD_W    = 6;
    localparam int DEF_MAX_ROUNDS  = 4;
    localparam int DEF_LEAK_EN     = 0;

    // Width needed to hold a round count from 0 up to max_rounds inclusive.
    function automatic int round_w(input int max_rounds);
        return $clog2(max_rounds + 1);
    endfunction

endpackage

// File: rtl/snn_idx_counter.sv
// Neuron index counter: sweeps 0..NUM_NEURONS-1 while enabled, held at 0 while cleared.
module snn_idx_counter
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic                           en,
    input  logic                           clr,
    output logic                           last,
    output logic [$clog2(NUM_NEURONS)-1:0] idx
);
    localparam int NW = $clog2(NUM_NEURONS);
    localparam logic [NW-1:0] LAST_IDX = NW'(NUM_NEURONS - 1);

    logic [NW-1:0] r_idx;

    // Clear has priority; an enabled count wraps to 0 after the last neuron.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_idx <= '0;
        end else if (clr) begin
            r_idx <= '0;
        end else if (en) begin
            r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        end
    end

    assign last = en && (r_idx == LAST_IDX);
    assign idx  = r_idx;

endmodule

// File: rtl/snn_layer_controller.sv
// Sequencer for one SNN layer: per-event weight load/accumulate, and a
// periodic timestep of spike rounds, optional leak and membrane writeback.
module snn_layer_controller
    import snn_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
    parameter int PERIOD_W    = DEF_PERIOD_W,
    parameter int MAX_ROUNDS  = DEF_MAX_ROUNDS,
    parameter int LEAK_EN     = DEF_LEAK_EN,
    localparam int NW = $clog2(NUM_NEURONS),
    localparam int IW = $clog2(NUM_INPUTS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   event_valid,
    output logic                   event_ready,
    input  logic [IW-1:0]          event_addr,
    input  logic [PERIOD_W-1:0]    period,
    input  logic [NUM_NEURONS-1:0] spike,
    input  logic                   overrun_clr,
    output logic                   accum_en,
    output logic                   weight_w_en,
    output logic                   memb_pot_w_en,
    output logic                   memb_pot_mem_w_en,
    output logic                   leak_en,
    output logic [IW+NW-1:0]       mem_addr,
    output logic [NW-1:0]          neuron_idx,
    output logic                   spike_done,
    output logic                   busy,
    output logic                   overrun
);
    localparam int RW = round_w(MAX_ROUNDS);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_ROUNDS);

    state_t              r_state;
    state_t              w_state_next;
    logic [PERIOD_W-1:0] r_period_cnt;
    logic [RW-1:0]       r_round;
    logic [IW-1:0]       r_addr;
    logic                r_overrun;
    logic                w_due;
    logic                w_any_spike;
    logic                w_accept;
    logic                w_idx_en;
    logic                w_idx_last;
    logic                w_overrun_set;

    assign w_due         = (r_period_cnt >= period);
    assign w_any_spike   = |spike;
    assign w_accept      = event_valid && event_ready;
    assign w_idx_en      = (r_state == LOAD) || (r_state == LEAK) || (r_state == STORE);
    assign w_overrun_set = (r_state == CLEANUP) && w_any_spike && (r_round >= MAX_R);

    // The index sweeps only in the per-neuron phases and sits at 0 elsewhere,
    // so each of those phases starts from neuron 0.
    snn_idx_counter #(
        .NUM_NEURONS(NUM_NEURONS)
    ) u_idx (
        .clock  (clock),
        .reset_n(reset_n),
        .en     (w_idx_en),
        .clr    (!w_idx_en),
        .last   (w_idx_last),
        .idx    (neuron_idx)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Timestep timer: restarts in SPIKE, otherwise counts up and parks at period.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_period_cnt <= '0;
        end else if (r_state == SPIKE) begin
            r_period_cnt <= '0;
        end else if (r_period_cnt < period) begin
            r_period_cnt <= r_period_cnt + 1'b1;
        end
    end

    // Spike round counter: one per SPIKE, cleared when the writeback finishes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_round <= '0;
        end else if (r_state == SPIKE) begin
            r_round <= r_round + 1'b1;
        end else if ((r_state == STORE) && w_idx_last) begin
            r_round <= '0;
        end
    end

    // Event source latch and sticky overrun flag (a new overrun beats a clear).
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= event_addr;
            end
            if (w_overrun_set) begin
                r_overrun <= 1'b1;
            end else if (overrun_clr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // Next-state logic and strobe decode; a due timestep outranks an event.
    always_comb begin
        w_state_next      = r_state;
        event_ready       = 1'b0;
        accum_en          = 1'b0;
        weight_w_en       = 1'b0;
        memb_pot_w_en     = 1'b0;
        memb_pot_mem_w_en = 1'b0;
        leak_en           = 1'b0;
        spike_done        = 1'b0;
        busy              = 1'b1;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_due) begin
                    w_state_next = SPIKE;
                end else begin
                    event_ready = 1'b1;
                    if (event_valid) begin
                        w_state_next = LOAD;
                    end
                end
            end
            LOAD: begin
                weight_w_en   = 1'b1;
                memb_pot_w_en = 1'b1;
                if (w_idx_last) begin
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                accum_en     = 1'b1;
                w_state_next = IDLE;
            end
            SPIKE: begin
                spike_done   = 1'b1;
                w_state_next = CLEANUP;
            end
            CLEANUP: begin
                if (w_any_spike && (r_round < MAX_R)) begin
                    w_state_next = SPIKE;
                end else if (LEAK_EN == 1) begin
                    w_state_next = LEAK;
                end else begin
                    w_state_next = STORE;
                end
            end
            LEAK: begin
                leak_en = 1'b1;
                if (w_idx_last) begin
                    w_state_next = STORE;
                end
            end
            STORE: begin
                memb_pot_mem_w_en = 1'b1;
                if (w_idx_last) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign mem_addr = {r_addr, neuron_idx};
    assign overrun  = r_overrun;

endmodule
